barrel_shift_pipe: RTL and testbench

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

---
 rtl/barrel_shift_pkg.sv | 15 +
 rtl/barrel_shift_stage.sv | 95 +++++++++
 rtl/barrel_shift_pipe.sv | 74 +++++++
 tb/tb_barrel_shift_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shift_pkg.sv
// Shared opcode definitions for the pipelined barrel shifter.
package barrel_shift_pkg;

    localparam int OP_W = 3;

    // Codes 5..7 are deliberately left undefined: every stage passes them through.
    typedef enum logic [OP_W-1:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_t;

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline stage of the barrel shifter. It applies a fixed shift of STEP
// positions when the matching shift-amount bit is set, and registers the
// result together with valid, opcode, shift amount and the original MSB.
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [OP_W-1:0]          in_op,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic                     in_msb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [OP_W-1:0]          out_op,
    output logic [$clog2(WIDTH)-1:0] out_shamt,
    output logic                     out_msb
);

    localparam int SW  = $clog2(WIDTH);
    localparam int BIT = $clog2(STEP);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [OP_W-1:0]  op_q,    op_d;
    logic [SW-1:0]    shamt_q, shamt_d;
    logic             msb_q,   msb_d;
    logic [WIDTH-1:0] shifted;

    // Bubble-collapsing: load whenever the register is empty or is being drained.
    assign in_ready = !valid_q || out_ready;

    // Fixed-distance shift for this stage; SRA fills with the operand's original MSB.
    always_comb begin
        shifted = in_data;
        if (in_shamt[BIT]) begin
            case (in_op)
                OP_SLL:  shifted = {in_data[WIDTH-1-STEP:0], {STEP{1'b0}}};
                OP_SRL:  shifted = {{STEP{1'b0}}, in_data[WIDTH-1:STEP]};
                OP_SRA:  shifted = {{STEP{in_msb}}, in_data[WIDTH-1:STEP]};
                OP_ROL:  shifted = {in_data[WIDTH-1-STEP:0], in_data[WIDTH-1:WIDTH-STEP]};
                OP_ROR:  shifted = {in_data[STEP-1:0], in_data[WIDTH-1:STEP]};
                default: shifted = in_data;
            endcase
        end
    end

    // Next-state: hold unless loading; payload only changes when a request enters.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        msb_d   = msb_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d  = shifted;
                op_d    = in_op;
                shamt_d = in_shamt;
                msb_d   = in_msb;
            end
        end
    end

    // Stage register; reset empties the stage and zeroes its payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            shamt_q <= '0;
            msb_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            msb_q   <= msb_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_op    = op_q;
    assign out_shamt = shamt_q;
    assign out_msb   = msb_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: log2(WIDTH) registered stages, stage k shifting by
// 2^k, with a valid/ready handshake on both sides and one result per cycle.
module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_shamt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Forward path between stages: index k feeds stage k, index SW is the output.
    logic [SW:0]      valid_c;
    logic [SW:0]      msb_c;
    logic [WIDTH-1:0] data_c  [SW+1];
    logic [OP_W-1:0]  op_c    [SW+1];
    logic [SW-1:0]    shamt_c [SW+1];
    logic             tail_unused;

    assign valid_c[0] = in_valid;
    assign data_c[0]  = in_data;
    assign op_c[0]    = in_op;
    assign shamt_c[0] = in_shamt;
    assign msb_c[0]   = in_data[WIDTH-1];

    // The ready chain uses one signal per stage so each link is a separate net.
    for (genvar gi = 0; gi < SW; gi++) begin : g_stage
        logic up_ready;
        logic down_ready;

        if (gi == SW-1) begin : g_tail
            assign down_ready = out_ready;
        end else begin : g_link
            assign down_ready = g_stage[gi+1].up_ready;
        end

        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .STEP  (1 << gi)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (valid_c[gi]),
            .in_ready  (up_ready),
            .in_data   (data_c[gi]),
            .in_op     (op_c[gi]),
            .in_shamt  (shamt_c[gi]),
            .in_msb    (msb_c[gi]),
            .out_valid (valid_c[gi+1]),
            .out_ready (down_ready),
            .out_data  (data_c[gi+1]),
            .out_op    (op_c[gi+1]),
            .out_shamt (shamt_c[gi+1]),
            .out_msb   (msb_c[gi+1])
        );
    end

    assign in_ready  = g_stage[0].up_ready;
    assign out_valid = valid_c[SW];
    assign out_data  = data_c[SW];

    // Side-band fields of the last stage are not needed at the output.
    assign tail_unused = ^{op_c[SW], shamt_c[SW], msb_c[SW]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed and randomised checks of barrel_shift_pipe at WIDTH=8.
module tb_barrel_shift_pipe;

    localparam int WIDTH = 8;
    localparam int SW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_shamt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    barrel_shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Whole-shift reference computed in one step.
    function automatic logic [7:0] ref_shift(input logic [2:0] op, input logic [7:0] d, input logic [2:0] s);
        logic [7:0] r;
        case (op)
            3'd0:    r = d << s;
            3'd1:    r = d >> s;
            3'd2:    r = $signed(d) >>> s;
            3'd3:    r = (d << s) | (d >> (4'd8 - s));
            3'd4:    r = (d >> s) | (d << (4'd8 - s));
            default: r = d;
        endcase
        return r;
    endfunction

    // One isolated request; starts and ends 1 time unit after a rising edge.
    task automatic run_vec(input string tag, input logic [2:0] op, input logic [7:0] d,
                           input logic [2:0] s, input logic [7:0] exp);
        int lat;
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        in_shamt  = s;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_rdy"}, in_ready, 1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 20);
        check_eq({tag, "_lat"}, lat, 3);
        check_eq(tag, out_data, exp);
        @(posedge clk); #1;
    endtask

    logic [7:0] bp_in  [5] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3};
    logic [7:0] bp_exp [5] = '{8'h03, 8'h84, 8'h48, 8'h30, 8'h87};
    logic [7:0] exp_q  [$];

    initial begin
        int sent;
        int got;
        int cyc;
        int quiet;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        out_ready = 1'b0;

        // Reset state and first cycle after release
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed vectors
        run_vec("sll_81_1", 3'd0, 8'h81, 3'd1, 8'h02);
        run_vec("srl_81_7", 3'd1, 8'h81, 3'd7, 8'h01);
        run_vec("sra_80_3", 3'd2, 8'h80, 3'd3, 8'hF0);
        run_vec("sra_70_3", 3'd2, 8'h70, 3'd3, 8'h0E);
        run_vec("op6_5a_5", 3'd6, 8'h5A, 3'd5, 8'h5A);
        run_vec("rol_96_4", 3'd3, 8'h96, 3'd4, 8'h69);
        run_vec("ror_81_1", 3'd4, 8'h81, 3'd1, 8'hC0);
        run_vec("rol_01_0", 3'd3, 8'h01, 3'd0, 8'h01);
        run_vec("srl_81_0", 3'd1, 8'h81, 3'd0, 8'h81);
        run_vec("ror_01_7", 3'd4, 8'h01, 3'd7, 8'h02);
        run_vec("sll_ff_7", 3'd0, 8'hFF, 3'd7, 8'h80);
        run_vec("op5_33_3", 3'd5, 8'h33, 3'd3, 8'h33);
        run_vec("sra_b5_6", 3'd2, 8'hB5, 3'd6, 8'hFE);

        // Backpressure: out_ready low for 10 cycles, 5 requests offered
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            if (sent < 5) begin
                in_valid = 1'b1; in_op = 3'd3; in_shamt = 3'd1; in_data = bp_in[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid) check_eq("bp_hold", out_data, bp_exp[0]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_eq("bp_accepted", sent, 3);
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;

        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 12) begin
            if (sent < 5) begin
                in_valid = 1'b1; in_op = 3'd3; in_shamt = 3'd1; in_data = bp_in[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                check_eq($sformatf("bp_out%0d", got), out_data, bp_exp[got]);
                got++;
            end else begin
                check_eq("bp_gap", out_valid, 1);
            end
            cyc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("bp_count", got, 5);

        // Reset with two requests in flight
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 3'd0; in_shamt = 3'd1; in_data = 8'h11;
        @(posedge clk); #1;
        in_data = 8'h22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_in_ready", in_ready, 1);
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) quiet++;
        end
        check_eq("mid_rst_no_output", quiet, 0);
        @(posedge clk); #1;

        // Random traffic against the reference model
        sent = 0;
        cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(3) != 0);
            in_op     = 3'($urandom_range(7));
            in_shamt  = 3'($urandom_range(7));
            in_data   = 8'($urandom_range(255));
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(in_op, in_data, in_shamt));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("rand_extra", out_valid, 0);
                else check_eq("rand", out_data, exp_q.pop_front());
            end
            cyc++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) check_eq("rand_extra", out_valid, 0);
                else check_eq("rand_drain", out_data, exp_q.pop_front());
            end
            @(posedge clk); #1;
        end
        check_eq("rand_sent", sent, 10000);
        check_eq("rand_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
